// File: rtl/conv_share_pkg.sv
// ---------------------------------------------------------------------------
// conv_share_pkg
//   Shared types and constants for the binary<->gray converter sharing
//   controller (conv_share_ctrl) and its round-robin arbiter.
//   Contents:
//     conv_state_e  controller FSM states
//     MODE_B2G/G2B  encoding of the per-request mode bit / conv_en
//     STAT_W        width of each per-requester grant counter
//     sat_inc       saturating increment for the grant counters
// ---------------------------------------------------------------------------
package conv_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } conv_state_e;

  localparam logic MODE_B2G = 1'b1;
  localparam logic MODE_G2B = 1'b0;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage : conv_share_pkg

// File: rtl/conv_rr_arbiter.sv
// ---------------------------------------------------------------------------
// conv_rr_arbiter
//   Combinational round-robin arbiter. Grants the first set request bit
//   found searching upward from ptr_i+1, wrapping at NREQ.
//   Ports:
//     req_i        in   NREQ  request vector
//     ptr_i        in   IDW   index of the most recently served requester
//     grant_o      out  NREQ  one-hot grant (0 when no request)
//     grant_idx_o  out  IDW   index of the granted requester
//     any_req_o    out  1     at least one request is set
// ---------------------------------------------------------------------------
module conv_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            any_req_o
);

  // Walk candidates from farthest (ptr) to nearest (ptr+1); the last hit
  // wins, so the nearest set bit after ptr ends up granted without a break.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    int idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_req_o   = |req_i;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDW'(idx);
      end
    end
  end

endmodule : conv_rr_arbiter

// File: rtl/conv_share_ctrl.sv
// ---------------------------------------------------------------------------
// conv_share_ctrl
//   Shares one combinational binary<->gray converter among NREQ requesters.
//   A round-robin arbiter picks a request in IDLE, its data/mode are latched
//   onto the converter inputs (DRIVE), the result is captured one settle
//   cycle later (CAPT) and returned on a single tagged response channel
//   (RESP). Accept in cycle T gives rsp_valid in cycle T+3.
//   Optional feature: define CONV_SHARE_STATS_EN to add grant_cnt, a
//   saturating 16-bit grant counter per requester.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     req_valid/ready/mode  per-requester handshake and mode (1=b2g, 0=g2b)
//     req_data              per-requester data, slice i = [i*WIDTH +: WIDTH]
//     conv_en, conv_data    to converter (en, data_in)
//     conv_b2g, conv_g2b    from converter
//     rsp_valid/ready       response handshake
//     rsp_id, rsp_data      responding requester index and converted result
//     busy                  1 whenever the FSM is not IDLE
//     grant_cnt             (stats build only) NREQ x 16-bit grant counters
// ---------------------------------------------------------------------------
module conv_share_ctrl
  import conv_share_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  conv_en,
  output logic [WIDTH-1:0]      conv_data,
  input  logic [WIDTH-1:0]      conv_b2g,
  input  logic [WIDTH-1:0]      conv_g2b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
`ifdef CONV_SHARE_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0] grant_cnt
`endif
);

  conv_state_e       state_q;
  logic [IDW-1:0]    ptr_q;
  logic              conv_en_q;
  logic [WIDTH-1:0]  conv_data_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [WIDTH-1:0]  rsp_data_q;

  logic [NREQ-1:0]   grant_oh;
  logic [IDW-1:0]    grant_idx;
  logic              any_req;

  conv_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant_oh),
    .grant_idx_o (grant_idx),
    .any_req_o   (any_req)
  );

  // The handshake is the single IDLE cycle in which the grant is shown.
  assign req_ready = (state_q == IDLE) ? grant_oh : '0;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);  // requester 0 wins first
      conv_en_q   <= 1'b0;
      conv_data_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            conv_data_q <= req_data[grant_idx*WIDTH +: WIDTH];
            conv_en_q   <= req_mode[grant_idx];
            rsp_id_q    <= grant_idx;
            state_q     <= DRIVE;
          end
        end
        DRIVE: state_q <= CAPT;  // converter settle cycle
        CAPT: begin
          rsp_data_q  <= (conv_en_q == MODE_B2G) ? conv_b2g : conv_g2b;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            ptr_q       <= rsp_id_q;
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conv_en   = conv_en_q;
  assign conv_data = conv_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

`ifdef CONV_SHARE_STATS_EN
  logic [STAT_W-1:0] cnt_q [NREQ];

  // NOTE: the counter array is small register state, not a RAM, so it is
  // reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
  end
`endif

endmodule : conv_share_ctrl

// File: tb/tb_conv_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_share_ctrl
//   Directed self-checking bench for conv_share_ctrl (WIDTH=8, NREQ=4).
//   A behavioural binary<->gray converter sits behind conv_gray_if and is
//   looped back onto the controller's converter ports. Inputs are driven and
//   outputs sampled around the falling clock edge.
//   Define CONV_SHARE_STATS_EN to also exercise grant_cnt.
// ---------------------------------------------------------------------------
interface conv_gray_if #(parameter int W = 8);
  logic         rst;
  logic         en;
  logic [W-1:0] data_in;
  logic [W-1:0] b2g;
  logic [W-1:0] g2b;

  always_comb begin
    logic acc;
    acc = 1'b0;
    b2g = '0;
    g2b = '0;
    if (!rst) begin
      b2g = data_in ^ (data_in >> 1);
      for (int i = W - 1; i >= 0; i--) begin
        acc    = acc ^ data_in[i];
        g2b[i] = acc;
      end
    end
  end
endinterface : conv_gray_if

module tb_conv_share_ctrl;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  conv_en;
  logic [WIDTH-1:0]      conv_data;
  logic [WIDTH-1:0]      conv_b2g;
  logic [WIDTH-1:0]      conv_g2b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
`ifdef CONV_SHARE_STATS_EN
  logic [NREQ*16-1:0]    grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv_gray_if #(.W(WIDTH)) cif ();
  assign cif.rst     = 1'b0;
  assign cif.en      = conv_en;
  assign cif.data_in = conv_data;
  assign conv_b2g    = cif.b2g;
  assign conv_g2b    = cif.g2b;

  conv_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .conv_en   (conv_en),
    .conv_data (conv_data),
    .conv_b2g  (conv_b2g),
    .conv_g2b  (conv_g2b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef CONV_SHARE_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One uncontended op with rsp_ready high; checks exact T..T+4 timing.
  task automatic run_op(input int id, input logic mode, input logic [7:0] din,
                        input logic [7:0] exp, input string tag);
    @(negedge clk);
    req_valid                   = '0;
    req_valid[id]               = 1'b1;
    req_mode[id]                = mode;
    req_data[id*WIDTH +: WIDTH] = din;
    rsp_ready                   = 1'b1;
    #1;
    check({tag, ".ready"}, 32'(req_ready), 32'(1 << id));
    @(negedge clk);  // T+1 DRIVE
    req_valid = '0;
    #1;
    check({tag, ".busy1"},  32'(busy), 32'd1);
    check({tag, ".cdata"},  32'(conv_data), 32'(din));
    check({tag, ".cen"},    32'(conv_en), 32'(mode));
    @(negedge clk);  // T+2 CAPT
    #1;
    check({tag, ".novalid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);  // T+3 RESP
    #1;
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".id"},    32'(rsp_id), 32'(id));
    check({tag, ".data"},  32'(rsp_data), 32'(exp));
    @(negedge clk);  // back in IDLE
    #1;
    check({tag, ".idle"},  32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int ord  [6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0] rexp [4] = '{8'h01, 8'h03, 8'h02, 8'h06};
    int last, ng, nr;

    rst_n     = 1'b0;
    req_valid = '0;
    req_mode  = '0;
    req_data  = '0;
    rsp_ready = 1'b0;

    // Reset values
    #12;
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.rspv",  32'(rsp_valid), 32'd0);
    check("rst.cdata", 32'(conv_data), 32'd0);
    check("rst.rdata", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single b2g then single g2b
    run_op(0, 1'b1, 8'h5A, 8'h77, "b2g");
    run_op(2, 1'b0, 8'h77, 8'h5A, "g2b");

    // Fairness: all valid, b2g, rsp_ready held high
    pulse_reset();
    req_mode  = '1;
    req_data  = {8'h04, 8'h03, 8'h02, 8'h01};
    rsp_ready = 1'b1;
    req_valid = '1;
    last = -1; ng = 0; nr = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (req_ready != '0) begin
        if (ng < 6) check("fair.order", 32'(req_ready), 32'(1 << ord[ng]));
        if (ng > 0) check("fair.gap", 32'(c - last), 32'd4);
        last = c;
        ng++;
      end
      if (rsp_valid) begin
        if (nr < 6) begin
          check("fair.rid",   32'(rsp_id), 32'(ord[nr]));
          check("fair.rdata", 32'(rsp_data), 32'(rexp[ord[nr]]));
        end
        nr++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("fair.ngrant", 32'(ng), 32'd6);
    check("fair.nrsp",   32'(nr), 32'd6);

    // Backpressure on requester 3 (ptr is 1 now)
    req_valid    = 4'b1000;
    req_mode[3]  = 1'b1;
    req_data[31:24] = 8'h0F;
    rsp_ready    = 1'b0;
    #1;
    check("bp.ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);  // RESP
    req_valid   = 4'b0001;  // competing request must not be granted
    req_mode[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp.valid", 32'(rsp_valid), 32'd1);
      check("bp.id",    32'(rsp_id), 32'd3);
      check("bp.data",  32'(rsp_data), 32'h08);
      check("bp.ready0", 32'(req_ready), 32'd0);
      check("bp.busy",  32'(busy), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    check("bp.hold", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    #1;
    check("bp.idle", 32'(busy), 32'd0);
    check("bp.drop", 32'(rsp_valid), 32'd0);

    // Reset mid-op (requester 1, g2b of 8'h33)
    @(negedge clk);
    req_valid       = 4'b0010;
    req_mode[1]     = 1'b0;
    req_data[15:8]  = 8'h33;
    #1;
    check("mid.ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);  // CAPT
    rst_n = 1'b0;
    #1;
    check("mid.rspv",  32'(rsp_valid), 32'd0);
    check("mid.busy",  32'(busy), 32'd0);
    check("mid.cdata", 32'(conv_data), 32'd0);
    check("mid.cen",   32'(conv_en), 32'd0);
    check("mid.rdata", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid       = 4'b1001;
    req_mode        = 4'b0001;
    req_data[7:0]   = 8'hA5;
    req_data[31:24] = 8'h11;
    #1;
    check("post.ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("post.id",   32'(rsp_id), 32'd0);
    check("post.data", 32'(rsp_data), 32'hF7);

    // Requester 3 alone right after reset
    pulse_reset();
    run_op(3, 1'b0, 8'h08, 8'h0F, "r3");

`ifdef CONV_SHARE_STATS_EN
    pulse_reset();
    for (int k = 0; k < 3; k++) run_op(1, 1'b1, 8'h02, 8'h03, "st");
    for (int i = 0; i < NREQ; i++)
      check("stats.cnt", 32'(grant_cnt[i*16 +: 16]), (i == 1) ? 32'd3 : 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_conv_share_ctrl
